// File: rtl/beep_out.sv
// Piezo beep sequencer: each TRIG pulse plays one square-wave burst followed by a
// silent gap, with up to MAXQ further requests held pending while busy.
module beep_out #(
    parameter int TONE_HALF = 12500,
    parameter int BEEP_LEN  = 5000000,
    parameter int GAP_LEN   = 2500000,
    parameter int MAXQ      = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic TRIG,
    input  logic MUTE,
    output logic BUZ,
    output logic BUSY,
    output logic OVF
);

    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int BW = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int DW = (BW > GW) ? BW : GW;
    localparam int PW = $clog2(MAXQ + 1);

    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
    localparam logic [DW-1:0] BEEP_LAST = DW'(BEEP_LEN - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_LEN - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAXQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [TW-1:0] tc_q, tc_d;
    logic          tone_q, tone_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          buz_q, buz_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            dur_q   <= '0;
            tc_q    <= '0;
            tone_q  <= 1'b0;
            pend_q  <= '0;
            buz_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            tc_q    <= tc_d;
            tone_q  <= tone_d;
            pend_q  <= pend_d;
            buz_q   <= buz_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        tc_d    = tc_q;
        tone_d  = tone_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (TRIG) begin
                    state_d = BEEP;
                    dur_d   = '0;
                    tc_d    = '0;
                    tone_d  = 1'b1;
                end
            end
            BEEP: begin
                if (dur_q == BEEP_LAST) begin
                    state_d = GAP;
                    dur_d   = '0;
                    tc_d    = '0;
                    tone_d  = 1'b0;
                end else begin
                    dur_d = dur_q + 1'b1;
                    if (tc_q == TONE_LAST) begin
                        tc_d   = '0;
                        tone_d = ~tone_q;
                    end else begin
                        tc_d = tc_q + 1'b1;
                    end
                end
                if (TRIG) begin
                    if (pend_q < PEND_MAX) pend_d = pend_q + 1'b1;
                    else                   ovf_d  = 1'b1;
                end
            end
            GAP: begin
                if (dur_q == GAP_LAST) begin
                    dur_d = '0;
                    // A same-cycle TRIG is consumed directly by this dequeue.
                    if (TRIG || pend_q != '0) begin
                        state_d = BEEP;
                        tc_d    = '0;
                        tone_d  = 1'b1;
                        if (!TRIG) pend_d = pend_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dur_d = dur_q + 1'b1;
                    if (TRIG) begin
                        if (pend_q < PEND_MAX) pend_d = pend_q + 1'b1;
                        else                   ovf_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                dur_d   = '0;
                tc_d    = '0;
                tone_d  = 1'b0;
                pend_d  = '0;
            end
        endcase

        buz_d  = tone_d & ~MUTE;
        busy_d = (state_d != IDLE) || (pend_d != '0);
    end

    assign BUZ  = buz_q;
    assign BUSY = busy_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_beep_out.sv
// Directed bench for beep_out with small timing parameters; cycle c is the
// output value sampled just after edge c-1 (edges counted from reset release).
module tb_beep_out;

    localparam int TH = 2;
    localparam int BL = 8;
    localparam int GL = 4;
    localparam int MQ = 2;

    logic clk = 1'b0;
    logic rst, trig, mute;
    logic buz, busy, ovf;

    always #5 clk = ~clk;

    beep_out #(.TONE_HALF(TH), .BEEP_LEN(BL), .GAP_LEN(GL), .MAXQ(MQ)) dut (
        .CLK(clk), .RST(rst), .TRIG(trig), .MUTE(mute),
        .BUZ(buz), .BUSY(busy), .OVF(ovf)
    );

    typedef struct packed {
        logic trig;
        logic mute;
        logic buz;
        logic busy;
        logic ovf;
    } vec_t;

    // Hand-listed burst start cycles (0 = unused), first BUSY-low cycle, OVF cycle.
    typedef struct packed {
        logic [79:0] trig_m;
        logic        mute;
        int          b0, b1, b2, b3;
        int          busy_end;
        int          ovf_cyc;
        int          last_edge;
    } scn_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int c, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, act, exp);
        end
    endtask

    function automatic logic tone_at(input int b, input int c);
        return (b > 0) && (c >= b) && (c < b + BL) && ((((c - b) / TH) % 2) == 0);
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        trig = 1'b0;
        mute = 1'b0;
        #1;
        chk("rst_buz", 0, buz, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_ovf", 0, ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_scn(input string nm, input scn_t s);
        logic eb;
        int   c;
        for (int ed = 1; ed <= s.last_edge; ed++) begin
            trig = s.trig_m[ed];
            mute = s.mute;
            @(posedge clk);
            #1;
            trig = 1'b0;
            c  = ed + 1;
            eb = (tone_at(s.b0, c) || tone_at(s.b1, c) || tone_at(s.b2, c) || tone_at(s.b3, c)) && !s.mute;
            chk({nm, "_buz"}, c, buz, eb);
            chk({nm, "_busy"}, c, busy, (c >= s.b0) && (c < s.busy_end));
            chk({nm, "_ovf"}, c, ovf, c == s.ovf_cyc);
        end
        mute = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        vec_t v[1:26];
        scn_t sc[4];
        string nm[4];
        scn_t s1;

        // Scenario 1 as an explicit per-edge table: TRIG at edge 10.
        for (int e = 1; e <= 26; e++) v[e] = '0;
        v[10].trig = 1'b1;
        for (int e = 10; e <= 21; e++) v[e].busy = 1'b1;
        v[10].buz = 1'b1; v[11].buz = 1'b1; v[14].buz = 1'b1; v[15].buz = 1'b1;

        // Two bursts back to back: one immediate, one queued during the gap.
        sc[0] = '0; nm[0] = "two";
        sc[0].trig_m[10] = 1'b1; sc[0].trig_m[20] = 1'b1;
        sc[0].b0 = 11; sc[0].b1 = 23; sc[0].busy_end = 35; sc[0].last_edge = 40;

        // Queue saturation: 4th TRIG in the first burst is dropped.
        sc[1] = '0; nm[1] = "sat";
        sc[1].trig_m[10] = 1'b1; sc[1].trig_m[12] = 1'b1;
        sc[1].trig_m[13] = 1'b1; sc[1].trig_m[14] = 1'b1;
        sc[1].b0 = 11; sc[1].b1 = 23; sc[1].b2 = 35;
        sc[1].busy_end = 47; sc[1].ovf_cyc = 15; sc[1].last_edge = 52;

        // TRIG on the final gap edge with a full queue: no drop, four bursts.
        sc[2] = '0; nm[2] = "gapend";
        sc[2].trig_m[10] = 1'b1; sc[2].trig_m[12] = 1'b1;
        sc[2].trig_m[13] = 1'b1; sc[2].trig_m[22] = 1'b1;
        sc[2].b0 = 11; sc[2].b1 = 23; sc[2].b2 = 35; sc[2].b3 = 47;
        sc[2].busy_end = 59; sc[2].last_edge = 62;

        // Muted single beep: BUZ silent, BUSY timing unchanged.
        sc[3] = '0; nm[3] = "mute";
        sc[3].trig_m[10] = 1'b1; sc[3].mute = 1'b1;
        sc[3].b0 = 11; sc[3].busy_end = 23; sc[3].last_edge = 26;

        s1 = '0;
        s1.trig_m[10] = 1'b1;
        s1.b0 = 11; s1.busy_end = 23; s1.last_edge = 26;

        do_reset();
        for (int e = 1; e <= 26; e++) begin
            trig = v[e].trig;
            mute = v[e].mute;
            @(posedge clk);
            #1;
            trig = 1'b0;
            chk("s1_buz", e + 1, buz, v[e].buz);
            chk("s1_busy", e + 1, busy, v[e].busy);
            chk("s1_ovf", e + 1, ovf, v[e].ovf);
        end

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_scn(nm[i], sc[i]);
        end

        // Asynchronous reset in the middle of a high tone phase, with one beep queued.
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            trig = (e == 10 || e == 13);
            @(posedge clk);
            #1;
            trig = 1'b0;
        end
        chk("abort_pre_buz", 15, buz, 1'b1);
        chk("abort_pre_busy", 15, busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_buz", 15, buz, 1'b0);
        chk("abort_busy", 15, busy, 1'b0);
        chk("abort_ovf", 15, ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_scn("after_abort", s1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
